rd_otf_converter: RTL and testbench
===================================

// Module: rd_otf_converter
// PURPOSE
//  Digit-serial on-the-fly converter: turns a redundant signed-digit (borrow-save, zp/zn pair per digit) stream, MSD-first, into a conventional two's-complement word.
//  Sits at the output end of the redundant adder / online operator datapath; no carry-propagate adder is needed.
//  Conversion is done one digit per cycle with Q/QM register pairs; the result is available the cycle after the last digit.
// PARAMETERS
//  NDIG  16              number of signed digits per operand (radix 2, MSD first)
//  CW    $clog2(NDIG+1)  width of internal digit counter
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  nReset     in   1        synchronous reset, active-low (sampled on posedge clk)
//  in_valid   in   1        digit on zp/zn is valid this cycle
//  in_ready   out  1        converter accepts a digit this cycle (transfer = in_valid & in_ready)
//  zp         in   1        positive bit of the signed digit
//  zn         in   1        negative bit of the signed digit; digit value = zp - zn
//  out_valid  out  1        q holds a completed result
//  out_ready  in   1        consumer takes result (transfer = out_valid & out_ready)
//  q          out  NDIG+1   two's-complement result, q = sum d_i*2^(NDIG-1-i), i=0 is MSD
// BEHAVIOUR
//  Reset (nReset=0 at posedge): state=IDLE, Q=0, QM=all ones, cnt=0, q=0, out_valid=0; in_ready=0 while nReset=0.
//  Digit decode: {zp,zn} 10=+1, 01=-1, 00=0, 11=0 (both treated as zero, no error).
//  Registers Q, QM are NDIG+1 bits; invariant QM = Q - 1 (mod 2^(NDIG+1)) after each accepted digit.
//  Update per accepted digit d (shift left, append):
//    d=+1: Q<={Q,1}   QM<={Q,0}
//    d= 0: Q<={Q,0}   QM<={QM,1}
//    d=-1: Q<={QM,1}  QM<={QM,0}
//  Initial Q=0, QM=-1 (all ones) at start of every conversion.
//  FSM:
//   IDLE: in_ready=1, out_valid=0. On transfer: apply first digit from initial Q/QM, cnt<=1, ->CONV (NDIG=1: ->DONE).
//   CONV: in_ready=1. On transfer: update, cnt<=cnt+1; when cnt==NDIG-1 (last digit) q<=new Q, ->DONE. No transfer: hold (bubbles allowed, no timeout).
//   DONE: in_ready=0, out_valid=1, q stable. On out_ready: out_valid<=0, Q<=0, QM<=all ones, cnt<=0, ->IDLE. Digit on in_valid in DONE is not consumed.
//  Latency: out_valid rises the cycle after the NDIG-th transfer; minimum throughput NDIG+1 cycles/result with out_ready held high.
//  No combinational path in_valid->in_ready or out_ready->out_valid; in_ready is a function of state only.
//  q updated only on entering DONE; holds value through IDLE/CONV until next completion (undefined-use, but deterministic).
//  Range: |result| <= 2^NDIG-1, always representable in NDIG+1 bits; no overflow possible.
//  Reset mid-conversion: partial digits discarded, reset values apply next cycle, first post-reset transfer starts a fresh word.
// TESTING
//  NDIG=16, 16 digits +1 back-to-back, out_ready=1 -> out_valid 1 cycle after 16th, q=17'h0FFFF (65535).
//  16 digits -1 -> q=17'h10001 (-65535); 16 digits 00 or 11 mixed -> q=0.
//  Alternating +1,-1 from MSD -> q=17'h05555 (21845); -1,+1 alternating -> q=17'h1AAAB (-21845).
//  Random in_valid gaps (~50%) with random digits, 1000 words -> q equals scoreboard sum of (zp-zn)*2^k each word.
//  out_ready low 5 cycles in DONE -> out_valid and q held, in_ready=0, offered digit not consumed; next word correct after release.
//  nReset low for 1 cycle after 7 digits -> out_valid=0, in_ready=1 next cycle; following 16 digits convert correctly.

Source files
------------

// File: rtl/rd_otf_converter.sv
// rd_otf_converter
// Digit-serial on-the-fly converter from a borrow-save signed-digit stream
// (MSD first, one digit per cycle) to an NDIG+1 bit two's-complement word.
// Q/QM register pairs (QM = Q - 1) avoid any carry-propagate addition.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high; ready never depends combinationally on the partner's valid.
module rd_otf_converter #(
   parameter int NDIG = 16,
   parameter int CW   = $clog2(NDIG + 1)
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            zp,
   input  logic            zn,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [NDIG:0]   q
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [NDIG:0] q_reg;
   logic [NDIG:0] qm_reg;
   logic [NDIG:0] q_nxt;
   logic [NDIG:0] qm_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last_digit;

   // Ready is held low during reset and while a result waits for the consumer.
   assign in_ready   = nReset && (state != S_DONE);
   assign out_valid  = (state == S_DONE);
   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt == CW'(NDIG - 1));

   // Next Q/QM for the digit on zp/zn; 11 decodes as zero like 00.
   always_comb begin
      q_nxt  = {q_reg[NDIG-1:0], 1'b0};
      qm_nxt = {qm_reg[NDIG-1:0], 1'b1};
      case ({zp, zn})
         2'b10: begin
            q_nxt  = {q_reg[NDIG-1:0], 1'b1};
            qm_nxt = {q_reg[NDIG-1:0], 1'b0};
         end
         2'b01: begin
            q_nxt  = {qm_reg[NDIG-1:0], 1'b1};
            qm_nxt = {qm_reg[NDIG-1:0], 1'b0};
         end
         default: begin
            q_nxt  = {q_reg[NDIG-1:0], 1'b0};
            qm_nxt = {qm_reg[NDIG-1:0], 1'b1};
         end
      endcase
   end

   // Conversion FSM: shift in digits until the last one, then hold the result.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state  <= S_IDLE;
         q_reg  <= '0;
         qm_reg <= '1;
         cnt    <= '0;
         q      <= '0;
      end else begin
         case (state)
            S_IDLE, S_CONV: begin
               if (accept) begin
                  q_reg  <= q_nxt;
                  qm_reg <= qm_nxt;
                  cnt    <= cnt + CW'(1);
                  if (last_digit) begin
                     q     <= q_nxt;
                     state <= S_DONE;
                  end else begin
                     state <= S_CONV;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  q_reg  <= '0;
                  qm_reg <= '1;
                  cnt    <= '0;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rd_otf_converter.sv
// tb_rd_otf_converter
// Self-checking bench for rd_otf_converter with NDIG=16.
module tb_rd_otf_converter;

   localparam int NDIG = 16;
   localparam int W    = NDIG + 1;

   logic         clk;
   logic         nReset;
   logic         in_valid;
   logic         in_ready;
   logic         zp;
   logic         zn;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   int           n_vec;
   int           n_err;

   rd_otf_converter #(.NDIG(NDIG)) dut (
      .clk       (clk),
      .nReset    (nReset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .zp        (zp),
      .zn        (zn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output monitor: every completed result is checked against the scoreboard.
   always @(negedge clk) begin
      if (nReset && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL result_unexpected: got q=%h with empty scoreboard", q);
         end else begin
            mon_exp = exp_q.pop_front();
            if (q !== mon_exp) begin
               n_err++;
               $display("FAIL result_value: got q=%h expected %h", q, mon_exp);
            end
         end
      end
   end

   // Offer one digit until accepted; gap_pct is the chance of a bubble cycle.
   task automatic drive_digit(input logic dzp, input logic dzn, input int gap_pct,
                              output bit ok);
      bit acc;
      int budget;
      acc    = 1'b0;
      budget = 0;
      ok     = 1'b1;
      while (!acc) begin
         in_valid = ($urandom_range(99) < gap_pct) ? 1'b0 : 1'b1;
         zp       = dzp;
         zn       = dzn;
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         budget++;
         if (!acc && budget > 300) begin
            n_vec++;
            n_err++;
            $display("FAIL digit_accept_timeout: in_ready=%b expected 1", in_ready);
            ok  = 1'b0;
            acc = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   // Send one full word (bit 15 is the MSD) and push its expected result.
   task automatic send_word(input logic [NDIG-1:0] zpv, input logic [NDIG-1:0] znv,
                            input int gap_pct);
      int e;
      bit ok;
      e = 0;
      for (int i = NDIG - 1; i >= 0; i--)
         e = e * 2 + int'(zpv[i]) - int'(znv[i]);
      exp_q.push_back(e[W-1:0]);
      for (int i = NDIG - 1; i >= 0; i--) begin
         drive_digit(zpv[i], znv[i], gap_pct, ok);
         if (!ok) return;
      end
   endtask

   // Wait until all pushed results have been observed.
   task automatic wait_drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      nReset    = 1'b0;
      in_valid  = 1'b0;
      zp        = 1'b0;
      zn        = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_vec++;
      if (q !== '0) begin
         n_err++;
         $display("FAIL reset_q: got %h expected 0", q);
      end
      @(posedge clk);
      #1;
      nReset = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_in_ready: got %b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   // Directed words with back-to-back digits, checking result latency.
   task automatic test_directed();
      logic [NDIG-1:0] zpv[6];
      logic [NDIG-1:0] znv[6];
      logic [NDIG-1:0] r;
      zpv[0] = 16'hFFFF; znv[0] = 16'h0000;
      zpv[1] = 16'h0000; znv[1] = 16'hFFFF;
      zpv[2] = 16'hAAAA; znv[2] = 16'h5555;
      zpv[3] = 16'h5555; znv[3] = 16'hAAAA;
      zpv[4] = 16'h0000; znv[4] = 16'h0000;
      r = 16'($urandom());
      zpv[5] = r;        znv[5] = r;
      for (int k = 0; k < 6; k++) begin
         send_word(zpv[k], znv[k], 0);
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_out_valid word %0d: got %b expected 1", k, out_valid);
         end
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_ready word %0d: got %b expected 0", k, in_ready);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL out_valid_clear word %0d: got %b expected 0", k, out_valid);
         end
         @(posedge clk);
         #1;
      end
      wait_drain();
   endtask

   // Back-to-back words with no idle cycles between them.
   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         send_word(16'($urandom()), 16'($urandom()), 0);
      wait_drain();
   endtask

   // Random digits (including 11) with ~50% bubbles.
   task automatic test_random();
      for (int k = 0; k < 1000; k++)
         send_word(16'($urandom()), 16'($urandom()), 50);
      wait_drain();
   endtask

   // Consumer stalls in DONE: result must hold and offered digit be ignored.
   task automatic test_hold();
      int budget;
      logic [W-1:0] held;
      out_ready = 1'b0;
      send_word(16'($urandom()), 16'($urandom()), 20);
      held = exp_q[0];
      budget = 0;
      while (!out_valid && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      in_valid = 1'b1;
      zp       = 1'b1;
      zn       = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_out_valid cycle %0d: got %b expected 1", c, out_valid);
         end
         n_vec++;
         if (q !== held) begin
            n_err++;
            $display("FAIL hold_q cycle %0d: got %h expected %h", c, q, held);
         end
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_in_ready cycle %0d: got %b expected 0", c, in_ready);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      send_word(16'h8001, 16'h0100, 0);
      send_word(16'($urandom()), 16'($urandom()), 30);
      wait_drain();
   endtask

   // Reset after 7 digits discards the partial word.
   task automatic test_reset_mid();
      bit ok;
      for (int i = 0; i < 7; i++)
         drive_digit(1'($urandom()), 1'($urandom()), 0, ok);
      nReset   = 1'b0;
      in_valid = 1'b1;
      zp       = 1'b1;
      zn       = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_in_ready_low: got %b expected 0", in_ready);
      end
      @(posedge clk);
      #1;
      nReset   = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      send_word(16'hF0F3, 16'h0C08, 0);
      wait_drain();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
